// File: rtl/round_referee.sv
// round_referee: referees one Tug-of-War round at a time.
// Waits a pseudo-random delay, lights GO, arbitrates the first press and
// presents a held (rw, wingame) level pair for the downstream game counter.
// Stops refereeing once the counter reports over; only rst leaves DONE.
// Optional build macro: ROUND_REFEREE_FALSE_START_EN. When it is defined, a
// press during WAIT is a false start and the opponent is awarded the point.
module round_referee #(
    parameter int DELAY_UNIT  = 50_000_000,
    parameter int HOLD_CYCLES = 8,
    parameter int GO_TIMEOUT  = 250_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic btn_l,
    input  logic btn_r,
    input  logic over,
    output logic rw,
    output logic wingame,
    output logic go_led,
    output logic busy
);

    // One shared down-counter serves the delay, timeout and hold phases,
    // so it is sized for the largest of the three.
    localparam int MAX_DLY = 16 * DELAY_UNIT;
    localparam int MAX_AB  = (MAX_DLY > GO_TIMEOUT) ? MAX_DLY : GO_TIMEOUT;
    localparam int MAX_CNT = (MAX_AB > HOLD_CYCLES) ? MAX_AB : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(GO_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [7:0]       LFSR_SEED    = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_GO     = 3'd2,
        ST_RESULT = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Fibonacci step for x^8+x^6+x^5+x^4+1; a non-zero seed never reaches zero.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] delay_load_s;
    logic [4:0]       dly_units_s;
    logic [7:0]       lfsr_r;
    logic [7:0]       lfsr_nxt_s;
    logic             btn_l_q_r;
    logic             btn_r_q_r;
    logic             press_l_s;
    logic             press_r_s;
    logic             right_win_r;
    logic             right_win_nxt_s;
    logic             rw_nxt_s;
    logic             wingame_nxt_s;
    logic             go_led_nxt_s;
    logic             busy_nxt_s;

    assign lfsr_nxt_s = lfsr_step(lfsr_r);
    assign press_l_s  = btn_l & ~btn_l_q_r;
    assign press_r_s  = btn_r & ~btn_r_q_r;

    // The counter runs from delay-1 down to zero, so GO comes exactly
    // delay cycles after WAIT entry. The draw uses the LFSR value that is
    // clocked in on the entry edge.
    assign dly_units_s  = {1'b0, lfsr_nxt_s[3:0]} + 5'd1;
    assign delay_load_s = CNT_W'(dly_units_s) * CNT_W'(DELAY_UNIT) - CNT_W'(1);

    // Next-state, counter reload and next-cycle output decode.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        right_win_nxt_s = right_win_r;
        case (state_r)
            ST_IDLE: begin
                if (over) begin
                    state_nxt_s = ST_DONE;
                end else if (start) begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = delay_load_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (over) begin
                    state_nxt_s = ST_DONE;
                end
`ifdef ROUND_REFEREE_FALSE_START_EN
                else if (press_l_s && press_r_s) begin
                    // Double false start: no point, draw a fresh delay.
                    cnt_nxt_s = delay_load_s;
                end else if (press_l_s) begin
                    state_nxt_s     = ST_RESULT;
                    right_win_nxt_s = 1'b1;
                    cnt_nxt_s       = HOLD_LOAD;
                end else if (press_r_s) begin
                    state_nxt_s     = ST_RESULT;
                    right_win_nxt_s = 1'b0;
                    cnt_nxt_s       = HOLD_LOAD;
                end
`endif
                else if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_GO;
                    cnt_nxt_s   = TIMEOUT_LOAD;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_GO: begin
                if (over) begin
                    state_nxt_s = ST_DONE;
                end else if (press_l_s && press_r_s) begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = delay_load_s;
                end else if (press_l_s) begin
                    state_nxt_s     = ST_RESULT;
                    right_win_nxt_s = 1'b0;
                    cnt_nxt_s       = HOLD_LOAD;
                end else if (press_r_s) begin
                    state_nxt_s     = ST_RESULT;
                    right_win_nxt_s = 1'b1;
                    cnt_nxt_s       = HOLD_LOAD;
                end else if (cnt_r == CNT_ZERO) begin
                    // Nobody pressed in time: abandon the round quietly.
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = delay_load_s;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_RESULT: begin
                // over is only looked at once the hold has run its length.
                if (cnt_r == CNT_ZERO) begin
                    if (over) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_WAIT;
                        cnt_nxt_s   = delay_load_s;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_DONE;
                cnt_nxt_s   = CNT_ZERO;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase

        go_led_nxt_s  = (state_nxt_s == ST_GO);
        busy_nxt_s    = (state_nxt_s == ST_WAIT) || (state_nxt_s == ST_GO) ||
                        (state_nxt_s == ST_RESULT);
        wingame_nxt_s = (state_nxt_s == ST_RESULT);
        rw_nxt_s      = wingame_nxt_s & right_win_nxt_s;
    end

    // State, counter, LFSR, button history and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            lfsr_r      <= LFSR_SEED;
            btn_l_q_r   <= 1'b0;
            btn_r_q_r   <= 1'b0;
            right_win_r <= 1'b0;
            rw          <= 1'b0;
            wingame     <= 1'b0;
            go_led      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            lfsr_r      <= lfsr_nxt_s;
            btn_l_q_r   <= btn_l;
            btn_r_q_r   <= btn_r;
            right_win_r <= right_win_nxt_s;
            rw          <= rw_nxt_s;
            wingame     <= wingame_nxt_s;
            go_led      <= go_led_nxt_s;
            busy        <= busy_nxt_s;
        end
    end

endmodule

// File: tb/tb_round_referee.sv
// tb_round_referee: randomized and directed stimulus for round_referee,
// checked every cycle against a time-stamped behavioural model of a round.
module tb_round_referee;

    localparam int DU = 2;
    localparam int HC = 4;
    localparam int GT = 40;

    localparam int PH_IDLE   = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_GO     = 2;
    localparam int PH_RESULT = 3;
    localparam int PH_DONE   = 4;

    logic clk = 1'b0;
    logic rst, start, btn_l, btn_r, over;
    logic rw, wingame, go_led, busy;

    int n_checks = 0;
    int n_errors = 0;

    // Model: absolute edge count and the edge at which each phase ends.
    int         t        = 0;
    int         ph       = PH_IDLE;
    int         go_at    = 0;
    int         deadline = 0;
    int         hold_end = 0;
    bit         m_right  = 1'b0;
    logic [7:0] m_lfsr   = 8'hA5;
    bit         pl_prev  = 1'b0;
    bit         pr_prev  = 1'b0;
    bit         e_rw, e_win, e_go, e_busy;

    int n;
    int first_delay_exp;

    round_referee #(
        .DELAY_UNIT (DU),
        .HOLD_CYCLES(HC),
        .GO_TIMEOUT (GT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .btn_l  (btn_l),
        .btn_r  (btn_r),
        .over   (over),
        .rw     (rw),
        .wingame(wingame),
        .go_led (go_led),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Feedback is the XOR of the polynomial taps 8,6,5,4 (bits 7,5,4,3).
    function automatic logic [7:0] lfsr_adv(input logic [7:0] v);
        logic [7:0] tapped;
        tapped = v & 8'b1011_1000;
        return {v[6:0], ^tapped};
    endfunction

    task automatic begin_wait(input logic [7:0] nl);
        go_at = t + (int'(nl[3:0]) + 1) * DU;
        ph    = PH_WAIT;
    endtask

    task automatic award(input bit right);
        m_right  = right;
        hold_end = t + HC;
        ph       = PH_RESULT;
    endtask

    task automatic model_step();
        logic [7:0] nl;
        bit pl, pr;
        t++;
        if (rst) begin
            ph      = PH_IDLE;
            m_lfsr  = 8'hA5;
            pl_prev = 1'b0;
            pr_prev = 1'b0;
        end else begin
            nl      = lfsr_adv(m_lfsr);
            pl      = btn_l && !pl_prev;
            pr      = btn_r && !pr_prev;
            pl_prev = btn_l;
            pr_prev = btn_r;
            case (ph)
                PH_IDLE: begin
                    if (over) ph = PH_DONE;
                    else if (start) begin_wait(nl);
                end
                PH_WAIT: begin
                    if (over) ph = PH_DONE;
`ifdef ROUND_REFEREE_FALSE_START_EN
                    else if (pl && pr) begin_wait(nl);
                    else if (pl) award(1'b1);
                    else if (pr) award(1'b0);
`endif
                    else if (t == go_at) begin
                        ph       = PH_GO;
                        deadline = t + GT;
                    end
                end
                PH_GO: begin
                    if (over) ph = PH_DONE;
                    else if (pl && pr) begin_wait(nl);
                    else if (pl) award(1'b0);
                    else if (pr) award(1'b1);
                    else if (t == deadline) begin_wait(nl);
                end
                PH_RESULT: begin
                    if (t == hold_end) begin
                        if (over) ph = PH_DONE;
                        else begin_wait(nl);
                    end
                end
                default: ;
            endcase
            m_lfsr = nl;
        end
        e_go   = (ph == PH_GO);
        e_busy = (ph == PH_WAIT) || (ph == PH_GO) || (ph == PH_RESULT);
        e_win  = (ph == PH_RESULT);
        e_rw   = e_win && m_right;
    endtask

    // One clock: model advances on the rising edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_eq("rw", rw, e_rw);
        check_eq("wingame", wingame, e_win);
        check_eq("go_led", go_led, e_go);
        check_eq("busy", busy, e_busy);
    endtask

    task automatic wait_go();
        int k;
        k = 0;
        while (!go_led && k < 200) begin
            cycle();
            k++;
        end
        check_eq("wait_go", go_led, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; btn_l = 1'b0; btn_r = 1'b0; over = 1'b0;
        first_delay_exp = (int'(lfsr_adv(8'hA5) & 8'h0F) + 1) * DU;

        repeat (3) cycle();

        // First round: start on the first edge after reset.
        rst = 1'b0; start = 1'b1;
        cycle();
        start = 1'b0;
        check_eq("busy_after_start", busy, 1);
        n = 0;
        while (!go_led && n < 100) begin
            cycle();
            n++;
        end
        check_eq("first_delay", n, first_delay_exp);

        // Right player wins the point.
        btn_r = 1'b1;
        cycle();
        btn_r = 1'b0;
        check_eq("go_fall", go_led, 0);
        check_eq("rw_rise", rw, 1);
        n = 0;
        while (wingame && n < 20) begin
            n++;
            cycle();
        end
        check_eq("hold_len", n, HC);
        check_eq("back_in_wait", busy, 1);

        // Tie in GO.
        wait_go();
        btn_l = 1'b1; btn_r = 1'b1;
        cycle();
        btn_l = 1'b0; btn_r = 1'b0;
        check_eq("tie_win", wingame, 0);
        check_eq("tie_go_fall", go_led, 0);
        check_eq("tie_busy", busy, 1);

        // Left press while waiting.
        cycle();
        btn_l = 1'b1;
        cycle();
        btn_l = 1'b0;
`ifdef ROUND_REFEREE_FALSE_START_EN
        check_eq("fs_win", wingame, 1);
        check_eq("fs_rw", rw, 1);
`else
        check_eq("early_ignored", wingame, 0);
`endif

        // Random play, busy then sparse button traffic (sparse lets timeouts occur).
        for (int i = 0; i < 1500; i++) begin
            start = 1'($urandom_range(0, 1));
            if (i < 750) begin
                btn_l = ($urandom_range(0, 7) == 0);
                btn_r = ($urandom_range(0, 7) == 0);
            end else begin
                btn_l = ($urandom_range(0, 63) == 0);
                btn_r = ($urandom_range(0, 63) == 0);
            end
            cycle();
        end
        btn_l = 1'b0; btn_r = 1'b0; start = 1'b0;
        cycle();

        // over during the hold: hold runs out in full, then DONE.
        wait_go();
        btn_l = 1'b1;
        cycle();
        btn_l = 1'b0;
        check_eq("over_round_win", wingame, 1);
        over = 1'b1;
        n = 0;
        while (wingame && n < 20) begin
            n++;
            cycle();
        end
        check_eq("over_hold_len", n, HC);
        check_eq("done_busy", busy, 0);
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            btn_l = 1'($urandom_range(0, 1));
            btn_r = 1'($urandom_range(0, 1));
            if (i == 10) over = 1'b0;
            cycle();
        end
        check_eq("done_sticky", busy, 0);

        // Reset mid-hold truncates wingame; LFSR reloads its seed.
        rst = 1'b1; start = 1'b0; btn_l = 1'b0; btn_r = 1'b0;
        cycle();
        rst = 1'b0; start = 1'b1;
        cycle();
        start = 1'b0;
        wait_go();
        btn_r = 1'b1;
        cycle();
        btn_r = 1'b0;
        cycle();
        check_eq("hold2_win", wingame, 1);
        rst = 1'b1;
        cycle();
        check_eq("rst_win", wingame, 0);
        check_eq("rst_rw", rw, 0);
        check_eq("rst_busy", busy, 0);
        rst = 1'b0; start = 1'b1;
        cycle();
        start = 1'b0;
        check_eq("idle_start", busy, 1);
        n = 0;
        while (!go_led && n < 100) begin
            cycle();
            n++;
        end
        check_eq("reload_delay", n, first_delay_exp);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
